// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with a load/busy handshake and a post-frame hold.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_serializer #(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] atx_data,
  input  logic       atx_load,
  output logic       atx_busy,
  output logic       tx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;

  localparam logic [15:0] DIV_TC    = 16'(CLK_DIV - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]  DMASK     = 8'((9'd1 << DATA_BITS) - 9'd1);

  logic [2:0]  r_state;
  logic [15:0] r_div;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_busy;
`ifdef UART_TX_PARITY_EN
  logic        r_par;
`endif

  logic w_tc;
  assign w_tc = (r_div == DIV_TC);

  assign tx       = r_tx;
  assign atx_busy = r_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (atx_load) begin
            r_shift <= atx_data & DMASK;
            r_div   <= '0;
            r_bit   <= '0;
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= ^(atx_data & DMASK);
`endif
          end
        end
        S_START: begin
          if (w_tc) begin
            r_div   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_div <= r_div + 16'd1;
          end
        end
        S_DATA: begin
          if (w_tc) begin
            r_div   <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == BIT_LAST) begin
              r_bit <= '0;
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_par;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= r_shift[1];
            end
          end else begin
            r_div <= r_div + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_tc) begin
            r_div   <= '0;
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_div <= r_div + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (w_tc) begin
            r_div <= '0;
            if (r_bit == STOP_LAST) begin
              r_bit   <= '0;
              r_state <= S_HOLD;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_div <= r_div + 16'd1;
          end
        end
        // Busy stays up until the CPU drops its load level.
        S_HOLD: begin
          if (!atx_load) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized bench for uart_tx_serializer against a frame-level model.
// Honors UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_serializer;

  localparam int CLK_DIV   = 4;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] atx_data = 8'h00;
  logic       atx_load = 1'b0;
  logic       atx_busy;
  logic       tx;

  int n_chk = 0;
  int n_fail = 0;

  uart_tx_serializer #(
    .CLK_DIV(CLK_DIV),
    .DATA_BITS(DATA_BITS),
    .STOP_BITS(STOP_BITS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .atx_data(atx_data),
    .atx_load(atx_load),
    .atx_busy(atx_busy),
    .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge. Load is high for 'hold' clk edges starting
  // with the acceptance edge; abort_k >= 0 pulses reset mid-frame.
  task automatic send(input logic [7:0] d, input int hold, input int abort_k);
    logic bits [0:15];
    int nb, n, kr, mx, busy_len;
    logic par;
    nb = 0;
    par = 1'b0;
    bits[nb] = 1'b0; nb++;
    for (int i = 0; i < DATA_BITS; i++) begin
      bits[nb] = d[i]; nb++;
      par ^= d[i];
    end
`ifdef UART_TX_PARITY_EN
    bits[nb] = par; nb++;
`endif
    for (int i = 0; i < STOP_BITS; i++) begin
      bits[nb] = 1'b1; nb++;
    end
    n  = nb * CLK_DIV;
    kr = hold - 1;
    mx = (n + 1 > kr + 1) ? n + 1 : kr + 1;
    busy_len = 0;
    atx_data = d;
    atx_load = 1'b1;
    for (int k = 0; k <= mx; k++) begin
      @(negedge clk);
      if (k == abort_k) begin
        reset_n = 1'b0;
        atx_load = 1'b0;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", atx_busy, 0);
        @(negedge clk);
        check("abort_hold_tx", tx, 1);
        reset_n = 1'b1;
        return;
      end
      check("tx", tx, (k < n) ? bits[k / CLK_DIV] : 1'b1);
      check("busy", atx_busy, (k < mx) ? 1 : 0);
      if (atx_busy) busy_len++;
      if (k == kr) atx_load = 1'b0;
      if (k == 2) atx_data = 8'($urandom);
    end
    check("busy_len", busy_len, mx);
  endtask

  initial begin
    atx_load = 1'b1;
    atx_data = 8'h55;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", atx_busy, 0);
    end
    reset_n = 1'b1;
    send(8'h55, 1, -1);
    send(8'h41, 100, -1);
    send(8'hAA, 1, -1);
    send(8'h07, 1, -1);
    send(8'h03, 3, -1);
    send(8'hC3, 1, 4 * CLK_DIV + 1);
    send(8'h5A, 1, -1);
    for (int r = 0; r < 12; r++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("idle_tx", tx, 1);
        check("idle_busy", atx_busy, 0);
      end
      send(8'($urandom), $urandom_range(1, 60), -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Asynchronous serial transmitter that consumes the CPU's atx_data / atx_load output words and drives atx_busy back into the CPU input mux.
- Sits directly downstream of the program ROM / CPU core on the DE0 nano top level and serializes one byte per load handshake onto the board TX pin.
- 8N1 framing by default, LSB first, line idles high.

Parameters:
- CLK_DIV, 434, clk cycles per bit period (50 MHz / 115200); legal range 2..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- STOP_BITS, 1, stop bit periods per frame; legal values 1 or 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- atx_data  in  8  byte to send; low DATA_BITS bits used; sampled only at load acceptance.
- atx_load  in  1  level request from CPU output word; frame starts on a high level seen while IDLE.
- atx_busy  out  1  high from the cycle after acceptance until the frame is done and atx_load has returned low.
- tx  out  1  serial line, idle high.

Behaviour:
- Reset is asynchronous and active-low on reset_n. While reset_n=0: tx=1, atx_busy=0, state=IDLE, bit counter=0, divider=0, shift register=0.
- Reset mid-frame aborts the frame immediately. tx goes high asynchronously. No partial frame resumes after release.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> HOLD -> IDLE.
- IDLE:
  - tx=1, atx_busy=0.
  - On a rising clk edge with atx_load=1: capture atx_data into the shift register, clear the divider, go to START.
  - atx_busy=1 and tx=0 from that edge. Latency: load high to busy high is 1 clk.
- Divider: counts 0..CLK_DIV-1. Each state lasts exactly CLK_DIV clks per bit. Terminal count advances the bit or the state.
- START: tx=0 for 1 bit period.
- DATA:
  - tx = shift register bit 0. Shift right at each terminal count.
  - Bit counter 0..DATA_BITS-1. After the last bit go to PARITY (if enabled) or STOP.
- STOP: tx=1 for STOP_BITS bit periods.
- HOLD:
  - Entered at the end of STOP. tx=1, atx_busy stays 1 while atx_load=1.
  - When atx_load=0, go to IDLE next edge; atx_busy=0 that edge.
  - If atx_load is already 0 at the end of STOP, HOLD lasts exactly 1 clk.
  - This guarantees one frame per load pulse regardless of how long the CPU holds atx_load.
- atx_load changes during START/DATA/STOP are ignored. atx_data changes after acceptance are ignored.
- Frame length: (1 + DATA_BITS + STOP_BITS [+1 parity]) * CLK_DIV clks from acceptance to HOLD entry.
- The CPU's busy-poll loop is slower than 1 clk. busy must therefore never glitch low between acceptance and HOLD exit.
- All outputs are registered; no combinational path from atx_load to tx or atx_busy.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA for 1 bit period.
  - tx = XOR of the DATA_BITS captured bits (even parity).
  - Frame grows by 1 bit period.
- Undefined: the PARITY state and its logic are absent. DATA goes directly to STOP.

Test Plan:
- Reset: hold reset_n=0 with atx_load=1 for 10 clks -> tx=1, atx_busy=0 throughout. After release with CLK_DIV=4, a frame starts on the first edge with atx_load=1.
- Basic frame, CLK_DIV=4, atx_data=0x55, atx_load pulsed for 1 clk:
  - atx_busy rises 1 clk after the load edge.
  - tx=0,1,0,1,0,1,0,1,0,1, each level held 4 clks.
  - atx_busy falls 1 clk after the stop bit ends (total 41 clks high).
- Long load: atx_data=0x41, atx_load held high 100 clks -> exactly one frame.
  - atx_busy stays 1 until 1 clk after atx_load falls.
  - No second start bit.
- Data change mid-frame: atx_data switches 0xAA -> 0x00 during DATA -> serialized bits still LSB-first 0xAA = 0,1,0,1,0,1,0,1.
- Reset mid-frame: reset_n pulsed low during data bit 3 -> tx=1 and atx_busy=0 immediately. The next load sends a complete fresh frame.
- UART_TX_PARITY_EN defined:
  - atx_data=0x07 -> parity bit 1; atx_data=0x03 -> parity bit 0.
  - Frame is 11 bit periods (44 clks at CLK_DIV=4).
